sm_ram_arbiter: RTL and testbench
=================================

Name: sm_ram_arbiter

Overview:
- Two-port arbiter sharing one single-port x32 data RAM (combinational read, write on posedge clk) between two requesters.
- Port 0 is the CPU data port; port 1 is the loader/debug port.
- Registers each granted access, drives the RAM for one cycle, then returns read data with a one-cycle ack pulse.
- Sits between the requesters and the data RAM in the top level.

Parameters:
WIDTH, 6, RAM byte-address width; RAM holds 2**(WIDTH-2) words; a[WIDTH-1:2] is the word index.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
req0  input  1  port 0 access request, held until ack0 or err0
we0  input  1  port 0 write enable, 1 = write
a0  input  32  port 0 byte address
wd0  input  32  port 0 write data
rd0  output  32  port 0 read data, valid while ack0 = 1
ack0  output  1  port 0 completion pulse
err0  output  1  port 0 out-of-range pulse
req1, we1, a1, wd1, rd1, ack1, err1  same widths and directions as port 0, for port 1
ram_a  output  32  RAM address
ram_we  output  1  RAM write enable
ram_wd  output  32  RAM write data
ram_rd  input  32  RAM read data, combinational from ram_a
busy  output  1  high when state is not IDLE

Behaviour:
- Clocking and reset
  - One clock; all state updates on posedge clk.
  - rst_n is sampled synchronously, active low.
  - Reset values: state = IDLE; last = 1 (port 0 wins the first tie); all output registers 0. This gives ram_a = 0, ram_we = 0, ram_wd = 0, rd0 = rd1 = 0, ack0/1 = 0, err0/1 = 0, busy = 0.
  - Reset mid-access: asserting rst_n = 0 in ACCESS forces ram_we to 0 in that same cycle, so no RAM write occurs. The pending ack is dropped.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
  - IDLE: sample req0 and req1.
    - Neither set: stay in IDLE.
    - One set: grant that port.
    - Both set: grant the port != last (round-robin).
    - On grant: latch sel, we, a, wd into registers; set last = sel.
    - If latched a[31:WIDTH] != 0, go to RESP with the error flag set and no RAM access. Otherwise go to ACCESS.
  - ACCESS: exactly one cycle.
    - ram_a = latched a; ram_wd = latched wd; ram_we = latched we.
    - At the closing edge, capture ram_rd into rd<sel> and go to RESP.
    - Read data is the pre-write contents; for writes it is don't-care.
  - RESP: exactly one cycle.
    - Normal access: ack<sel> = 1.
    - Error: err<sel> = 1 instead of ack, and rd<sel> = 0.
    - Next state: IDLE.
- Outside ACCESS, ram_we = 0 and ram_a/ram_wd hold their last values.
- Latency: req sampled in cycle t -> RAM driven in cycle t+1 -> ack in cycle t+2. Peak throughput is one access per 3 cycles.
- Requester rules
  - Hold req, we, a, wd stable until ack or err.
  - Deassert req in the cycle after ack/err unless a new access is wanted. req is re-sampled only in IDLE.
- req inputs are ignored during ACCESS and RESP. A request raised then waits for IDLE.
- Simultaneous requests with both ports held continuously alternate 0,1,0,1, so no starvation.
- The ungranted port's rd and ack are unchanged; rd<N> holds its value until that port's next completion.
- Address bits a[1:0] are ignored; accesses are always full-word.

Optional Feature:
- Macro: SM_RAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests and the last register is removed. Port 1 can starve while port 0 requests back-to-back.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with req0 = req1 = 1 -> busy = 0, ack0/1 = 0, ram_we = 0 throughout; after release, port 0 is granted first.
- Port 1 write then port 0 read: port 1 writes a1 = 0x0C, wd1 = 0xDEADBEEF -> ram_we = 1 for exactly one cycle with ram_a = 0x0C, then ack1 pulses. Port 0 then reads a0 = 0x0C -> ack0 arrives 2 cycles after sampling with rd0 = 0xDEADBEEF.
- Simultaneous requests held continuously, port 0 reading 0x04 and port 1 reading 0x08 -> grant order 0,1,0,1; each ack is exactly one cycle; ack0 and ack1 are never high together.
- Out of range: a0 = 0x40 with WIDTH = 6 -> err0 pulses in cycle t+1, rd0 = 0, ram_we stays 0, and RAM contents are unchanged on readback.
- Reset during ACCESS of a write of 0x12345678 to 0x10 -> no ack; a later read of 0x10 returns the old value.
- With SM_RAM_ARB_FIXED_PRIO_EN defined and both ports requesting continuously -> port 0 is granted every time and ack1 never asserts.

Source files
------------

// File: rtl/sm_ram_arbiter_if.sv
// Bus bundle for sm_ram_arbiter: two requester ports, the data-RAM side and busy.
// master = requesters + RAM model, slave = the arbiter.
interface sm_ram_arbiter_if;
    logic        req0;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [31:0] rd0;
    logic        ack0;
    logic        err0;

    logic        req1;
    logic        we1;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic [31:0] rd1;
    logic        ack1;
    logic        err1;

    logic [31:0] ram_a;
    logic        ram_we;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;
    logic        busy;

    modport master (
        output req0, we0, a0, wd0, req1, we1, a1, wd1, ram_rd,
        input  rd0, ack0, err0, rd1, ack1, err1, ram_a, ram_we, ram_wd, busy
    );

    modport slave (
        input  req0, we0, a0, wd0, req1, we1, a1, wd1, ram_rd,
        output rd0, ack0, err0, rd1, ack1, err1, ram_a, ram_we, ram_wd, busy
    );
endinterface

// File: rtl/sm_ram_arbiter.sv
// Two-port arbiter for a single-port x32 data RAM (IDLE -> ACCESS -> RESP).
// Define SM_RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sm_ram_arbiter #(
    parameter int unsigned WIDTH = 6
) (
    input logic             clk,
    input logic             rst_n,
    sm_ram_arbiter_if.slave bus
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        sel_q;
    logic        we_q;
    logic [31:0] ram_a_q;
    logic [31:0] ram_wd_q;
    logic [31:0] rd0_q, rd1_q;
    logic        ack0_q, ack1_q;
    logic        err0_q, err1_q;

    logic        any_req;
    logic        grant_sel;
    logic [31:0] grant_a;
    logic        grant_oor;

    assign any_req = bus.req0 | bus.req1;

`ifdef SM_RAM_ARB_FIXED_PRIO_EN
    assign grant_sel = ~bus.req0;
`else
    logic last_q;

    assign grant_sel = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_q == StIdle && any_req) begin
            last_q <= grant_sel;
        end
    end
`endif

    assign grant_a   = grant_sel ? bus.a1 : bus.a0;
    assign grant_oor = |grant_a[31:WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (any_req) state_d = grant_oor ? StResp : StAccess;
            StAccess: state_d = StResp;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            ram_a_q  <= '0;
            ram_wd_q <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        sel_q <= grant_sel;
                        we_q  <= grant_sel ? bus.we1 : bus.we0;
                        // Out-of-range grants skip the RAM, so ram_a/ram_wd keep their values.
                        if (grant_oor) begin
                            if (grant_sel) begin
                                err1_q <= 1'b1;
                                rd1_q  <= '0;
                            end else begin
                                err0_q <= 1'b1;
                                rd0_q  <= '0;
                            end
                        end else begin
                            ram_a_q  <= grant_a;
                            ram_wd_q <= grant_sel ? bus.wd1 : bus.wd0;
                        end
                    end
                end
                StAccess: begin
                    if (sel_q) begin
                        rd1_q  <= bus.ram_rd;
                        ack1_q <= 1'b1;
                    end else begin
                        rd0_q  <= bus.ram_rd;
                        ack0_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by rst_n so a reset landing in ACCESS suppresses the write.
    assign bus.ram_we = (state_q == StAccess) & we_q & rst_n;
    assign bus.ram_a  = ram_a_q;
    assign bus.ram_wd = ram_wd_q;
    assign bus.rd0    = rd0_q;
    assign bus.rd1    = rd1_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.err0   = err0_q;
    assign bus.err1   = err1_q;
    assign bus.busy   = (state_q != StIdle);
endmodule

// File: tb/tb_sm_ram_arbiter.sv
// Directed self-checking bench for sm_ram_arbiter with a 16-word behavioural RAM.
// Builds with or without SM_RAM_ARB_FIXED_PRIO_EN.
module tb_sm_ram_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sm_ram_arbiter_if bus ();

    sm_ram_arbiter #(
        .WIDTH(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem [16];

    assign bus.ram_rd = mem[bus.ram_a[5:2]];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_a[5:2]] <= bus.ram_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.we0  = 1'b0;
        bus.we1  = 1'b0;
    endtask

    // Raises one request, waits (bounded) for ack/err, then returns the bus to IDLE.
    task automatic access(input bit port, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output int lat, output bit got_ack, output bit got_err);
        rdata   = '0;
        lat     = 0;
        got_ack = 1'b0;
        got_err = 1'b0;
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.a1 = a; bus.wd1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.a0 = a; bus.wd0 = wd;
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (port ? (bus.ack1 | bus.err1) : (bus.ack0 | bus.err0)) begin
                lat     = i;
                got_ack = port ? bus.ack1 : bus.ack0;
                got_err = port ? bus.err1 : bus.err0;
                rdata   = port ? bus.rd1 : bus.rd0;
                break;
            end
        end
        drop_reqs();
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.a0 = 32'h04; bus.wd0 = '0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.a1 = 32'h08; bus.wd1 = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.busy !== 1'b0 || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 ||
                bus.ram_we !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: busy=%b ack0=%b ack1=%b ram_we=%b required all 0",
                         bus.busy, bus.ack0, bus.ack1, bus.ram_we);
            end
            total++;
            if (bus.ram_a !== 32'h0 || bus.rd0 !== 32'h0 || bus.rd1 !== 32'h0 ||
                bus.err0 !== 1'b0 || bus.err1 !== 1'b0) begin
                bad++;
                $display("FAIL reset_regs: ram_a=%h rd0=%h rd1=%h err0=%b err1=%b required 0",
                         bus.ram_a, bus.rd0, bus.rd1, bus.err0, bus.err1);
            end
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.ram_a !== 32'h04) begin
            bad++;
            $display("FAIL reset_first_grant: busy=%b ram_a=%h required 1 and 00000004",
                     bus.busy, bus.ram_a);
        end
        tick();
        total++;
        if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_ack: ack0=%b ack1=%b required 1 0", bus.ack0, bus.ack1);
        end
        drop_reqs();
        tick();
    endtask

    task automatic test_write_read();
        logic [31:0] rdata;
        int          lat;
        bit          ga, ge;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.a1 = 32'h0C; bus.wd1 = 32'hDEADBEEF;
        total++;
        if (bus.ram_we !== 1'b0) begin
            bad++;
            $display("FAIL wr_idle_we: ram_we=%b required 0", bus.ram_we);
        end
        tick();
        total++;
        if (bus.ram_we !== 1'b1 || bus.ram_a !== 32'h0C || bus.ram_wd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_access: ram_we=%b ram_a=%h ram_wd=%h required 1 0000000c deadbeef",
                     bus.ram_we, bus.ram_a, bus.ram_wd);
        end
        tick();
        total++;
        if (bus.ram_we !== 1'b0 || bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0) begin
            bad++;
            $display("FAIL wr_resp: ram_we=%b ack1=%b ack0=%b required 0 1 0",
                     bus.ram_we, bus.ack1, bus.ack0);
        end
        drop_reqs();
        tick();
        total++;
        if (bus.ack1 !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL wr_ack_pulse: ack1=%b busy=%b required 0 0", bus.ack1, bus.busy);
        end
        access(1'b0, 1'b0, 32'h0C, 32'h0, rdata, lat, ga, ge);
        total++;
        if (lat !== 2 || ga !== 1'b1 || ge !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_after_wr: lat=%0d ack=%b err=%b rd0=%h required 2 1 0 deadbeef",
                     lat, ga, ge, rdata);
        end
    endtask

    // Both ports held continuously; checks grant order and ack exclusivity.
    task automatic test_contention();
        logic [31:0] rdata;
        int          lat;
        bit          ga, ge;
        int          nacks;
        bit          prev0, prev1;
        bit          exp_port [4];
`ifdef SM_RAM_ARB_FIXED_PRIO_EN
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        access(1'b1, 1'b1, 32'h04, 32'h44444444, rdata, lat, ga, ge);
        access(1'b1, 1'b1, 32'h08, 32'h88888888, rdata, lat, ga, ge);
        nacks = 0;
        prev0 = 1'b0;
        prev1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.a0 = 32'h04;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.a1 = 32'h08;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin
                total++;
                bad++;
                $display("FAIL cont_both_ack: ack0=1 ack1=1 at cycle %0d required exclusive", i);
            end
            if ((bus.ack0 === 1'b1 && prev0) || (bus.ack1 === 1'b1 && prev1)) begin
                total++;
                bad++;
                $display("FAIL cont_ack_width: ack held two cycles at %0d required 1 cycle", i);
            end
            if ((bus.ack0 === 1'b1 || bus.ack1 === 1'b1) && nacks < 4) begin
                total++;
                if (bus.ack1 !== exp_port[nacks]) begin
                    bad++;
                    $display("FAIL cont_order: ack #%0d from port %b required port %b",
                             nacks, bus.ack1, exp_port[nacks]);
                end
                total++;
                if ((bus.ack0 === 1'b1 && bus.rd0 !== 32'h44444444) ||
                    (bus.ack1 === 1'b1 && bus.rd1 !== 32'h88888888)) begin
                    bad++;
                    $display("FAIL cont_data: rd0=%h rd1=%h required 44444444 / 88888888",
                             bus.rd0, bus.rd1);
                end
                nacks++;
            end
            prev0 = bus.ack0;
            prev1 = bus.ack1;
        end
        drop_reqs();
        tick();
        total++;
        if (nacks !== 4 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL cont_count: acks=%0d busy=%b required 4 0", nacks, bus.busy);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rdata;
        int          lat;
        bit          ga, ge;
        access(1'b1, 1'b1, 32'h00, 32'hA5A5A5A5, rdata, lat, ga, ge);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.a0 = 32'h40; bus.wd0 = 32'hFFFFFFFF;
        tick();
        total++;
        if (bus.err0 !== 1'b1 || bus.ack0 !== 1'b0 || bus.rd0 !== 32'h0 || bus.ram_we !== 1'b0) begin
            bad++;
            $display("FAIL oor_resp: err0=%b ack0=%b rd0=%h ram_we=%b required 1 0 00000000 0",
                     bus.err0, bus.ack0, bus.rd0, bus.ram_we);
        end
        drop_reqs();
        tick();
        total++;
        if (bus.err0 !== 1'b0 || bus.busy !== 1'b0 || bus.ram_we !== 1'b0) begin
            bad++;
            $display("FAIL oor_after: err0=%b busy=%b ram_we=%b required 0 0 0",
                     bus.err0, bus.busy, bus.ram_we);
        end
        access(1'b0, 1'b0, 32'h00, 32'h0, rdata, lat, ga, ge);
        total++;
        if (lat !== 2 || ga !== 1'b1 || rdata !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL oor_readback: lat=%0d ack=%b rd0=%h required 2 1 a5a5a5a5",
                     lat, ga, rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rdata;
        int          lat;
        bit          ga, ge;
        access(1'b1, 1'b1, 32'h10, 32'h11111111, rdata, lat, ga, ge);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.a0 = 32'h10; bus.wd0 = 32'h12345678;
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.ram_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_we: ram_we=%b required 0", bus.ram_we);
        end
        tick();
        total++;
        if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ack: ack0=%b busy=%b required 0 0", bus.ack0, bus.busy);
        end
        drop_reqs();
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.ack0 !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_late_ack: ack0=%b required 0", bus.ack0);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, rdata, lat, ga, ge);
        total++;
        if (lat !== 2 || ga !== 1'b1 || rdata !== 32'h11111111) begin
            bad++;
            $display("FAIL rst_mid_readback: lat=%0d ack=%b rd0=%h required 2 1 11111111",
                     lat, ga, rdata);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.a0 = '0; bus.wd0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.a1 = '0; bus.wd1 = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
